// File: rtl/display_pkg.sv
// Shared screen codes, FSM states and player colour constants for the LED renderer.
// Pure definitions; no logic, latency or flow control of its own.
package display_pkg;

  localparam logic [7:0] INTENSITY = 8'h20;

  // GRB packing: G[23:16] R[15:8] B[7:0]
  localparam logic [23:0] COL_BLACK  = 24'h000000;
  localparam logic [23:0] COL_GREEN  = {INTENSITY, 8'h00, 8'h00};
  localparam logic [23:0] COL_RED    = {8'h00, INTENSITY, 8'h00};
  localparam logic [23:0] COL_BLUE   = {8'h00, 8'h00, INTENSITY};
  localparam logic [23:0] COL_YELLOW = {INTENSITY, INTENSITY, 8'h00};

  typedef enum logic [1:0] {
    SCR_MENU      = 2'd0,
    SCR_COUNTDOWN = 2'd1,
    SCR_GAME      = 2'd2,
    SCR_WIN       = 2'd3
  } screen_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SNAPSHOT = 2'd1,
    ST_STREAM   = 2'd2,
    ST_DONE     = 2'd3
  } render_state_t;

  function automatic logic [23:0] player_color(input int k);
    case (k)
      0:       player_color = COL_GREEN;
      1:       player_color = COL_RED;
      2:       player_color = COL_BLUE;
      default: player_color = COL_YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/pixel_colorizer.sv
// Per-pixel colour lookup from the frame snapshot for the selected screen.
// Purely combinational, zero latency; no flow control.
// Output depends only on screen, index and the registered snapshot.
module pixel_colorizer
  import display_pkg::*;
#(
  parameter int MAX_POS   = 16,
  parameter int N_PLAYERS = 4,
  localparam int POS_W    = $clog2(MAX_POS)
) (
  input  screen_t                      screen,
  input  logic [POS_W-1:0]             index,
  input  logic [N_PLAYERS-1:0]         snap_ready,
  input  logic [N_PLAYERS*POS_W-1:0]   snap_pos,
  input  logic [2:0]                   snap_countdown,
  output logic [23:0]                  grb
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(MAX_POS - 1);

  always_comb begin
    grb = COL_BLACK;
    case (screen)
      SCR_MENU: begin
        for (int k = 0; k < N_PLAYERS; k++) begin
          if (int'(index) == k && snap_ready[k]) grb = player_color(k);
        end
      end
      SCR_COUNTDOWN: begin
        if (int'(index) < int'(snap_countdown)) grb = COL_RED;
      end
      SCR_GAME: begin
        for (int k = 0; k < N_PLAYERS; k++) begin
          if (snap_ready[k] && snap_pos[k*POS_W +: POS_W] == index)
            grb = grb | player_color(k);
        end
      end
      default: begin
        // Walk downwards so the lowest-index winner is the last write.
        for (int k = N_PLAYERS - 1; k >= 0; k--) begin
          if (snap_ready[k] && snap_pos[k*POS_W +: POS_W] == LAST_POS)
            grb = player_color(k);
        end
      end
    endcase
  end

endmodule

// File: rtl/frame_renderer.sv
// Renders one LED frame from a snapshot of game state and streams it pixel by pixel.
// Latency: frame_start to frame_done is MAX_POS+1 cycles with pix_ready held high.
// Backpressure: valid/ready per pixel; index and colour hold while pix_ready is low.
module frame_renderer
  import display_pkg::*;
#(
  parameter int MAX_POS   = 16,
  parameter int N_PLAYERS = 4,
  localparam int POS_W    = $clog2(MAX_POS)
) (
  input  logic                         clk,
  input  logic                         reset_all,
  input  logic [N_PLAYERS-1:0]         player_ready,
  input  logic [N_PLAYERS*POS_W-1:0]   player_pos,
  input  logic [N_PLAYERS-1:0]         player_activity,
  input  logic                         menu_activity,
  input  logic                         is_in_menu,
  input  logic [2:0]                   countdown,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [POS_W-1:0]             pix_index,
  output logic [23:0]                  pix_grb,
  output logic                         frame_start,
  output logic                         frame_done,
  output logic                         busy,
  output logic [1:0]                   current_screen
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(MAX_POS - 1);

  render_state_t               state, state_nx;
  logic                        pending;
  screen_t                     screen_q, screen_sel;
  logic [N_PLAYERS-1:0]        snap_ready;
  logic [N_PLAYERS*POS_W-1:0]  snap_pos;
  logic [2:0]                  snap_countdown;
  logic [23:0]                 color_grb;
  logic                        win_hit;

  always_comb begin
    win_hit = 1'b0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (player_ready[k] && player_pos[k*POS_W +: POS_W] == LAST_POS) win_hit = 1'b1;
    end
    if (is_in_menu)             screen_sel = SCR_MENU;
    else if (countdown != 3'd0) screen_sel = SCR_COUNTDOWN;
    else if (win_hit)           screen_sel = SCR_WIN;
    else                        screen_sel = SCR_GAME;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (pending) state_nx = ST_SNAPSHOT;
      ST_SNAPSHOT: state_nx = ST_STREAM;
      ST_STREAM:   if (pix_ready && pix_index == LAST_POS) state_nx = ST_DONE;
      default:     state_nx = pending ? ST_SNAPSHOT : ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      state          <= ST_IDLE;
      pending        <= 1'b1;
      pix_index      <= '0;
      screen_q       <= SCR_MENU;
      snap_ready     <= '0;
      snap_pos       <= '0;
      snap_countdown <= '0;
    end else begin
      state   <= state_nx;
      // New activity wins over the clear so a strobe on the entry cycle is not lost.
      pending <= (pending && (state_nx != ST_SNAPSHOT)) || (|player_activity) || menu_activity;
      if (state == ST_SNAPSHOT) begin
        snap_ready     <= player_ready;
        snap_pos       <= player_pos;
        snap_countdown <= countdown;
        screen_q       <= screen_sel;
        pix_index      <= '0;
      end else if (state == ST_STREAM && pix_ready) begin
        pix_index <= pix_index + POS_W'(1);
      end
    end
  end

  pixel_colorizer #(
    .MAX_POS   (MAX_POS),
    .N_PLAYERS (N_PLAYERS)
  ) u_colorizer (
    .screen         (screen_q),
    .index          (pix_index),
    .snap_ready     (snap_ready),
    .snap_pos       (snap_pos),
    .snap_countdown (snap_countdown),
    .grb            (color_grb)
  );

  assign pix_valid      = (state == ST_STREAM);
  assign pix_grb        = pix_valid ? color_grb : COL_BLACK;
  assign frame_start    = (state == ST_SNAPSHOT);
  assign frame_done     = (state == ST_DONE);
  assign busy           = (state != ST_IDLE);
  assign current_screen = screen_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Randomised and directed bench for frame_renderer against a frame-level reference model.
module tb_frame_renderer;

  localparam int MAX_POS   = 16;
  localparam int N_PLAYERS = 4;
  localparam int POS_W     = $clog2(MAX_POS);

  logic                        clk = 1'b0;
  logic                        reset_all = 1'b1;
  logic [N_PLAYERS-1:0]        player_ready = '0;
  logic [N_PLAYERS*POS_W-1:0]  player_pos = '0;
  logic [N_PLAYERS-1:0]        player_activity = '0;
  logic                        menu_activity = 1'b0;
  logic                        is_in_menu = 1'b1;
  logic [2:0]                  countdown = 3'd0;
  logic                        pix_valid;
  logic                        pix_ready = 1'b1;
  logic [POS_W-1:0]            pix_index;
  logic [23:0]                 pix_grb;
  logic                        frame_start;
  logic                        frame_done;
  logic                        busy;
  logic [1:0]                  current_screen;

  always #5 clk = ~clk;

  frame_renderer #(.MAX_POS(MAX_POS), .N_PLAYERS(N_PLAYERS)) dut (
    .clk             (clk),
    .reset_all       (reset_all),
    .player_ready    (player_ready),
    .player_pos      (player_pos),
    .player_activity (player_activity),
    .menu_activity   (menu_activity),
    .is_in_menu      (is_in_menu),
    .countdown       (countdown),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_index       (pix_index),
    .pix_grb         (pix_grb),
    .frame_start     (frame_start),
    .frame_done      (frame_done),
    .busy            (busy),
    .current_screen  (current_screen)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference rules, written from the display definitions.
  function automatic logic [23:0] pcol(input int k);
    case (k)
      0:       return 24'h200000;
      1:       return 24'h002000;
      2:       return 24'h000020;
      default: return 24'h202000;
    endcase
  endfunction

  function automatic int pos_of(input logic [N_PLAYERS*POS_W-1:0] p, input int k);
    return int'(p[k*POS_W +: POS_W]);
  endfunction

  function automatic logic [1:0] screen_of(input logic menu, input logic [2:0] cd,
                                           input logic [N_PLAYERS-1:0] rdy,
                                           input logic [N_PLAYERS*POS_W-1:0] p);
    if (menu) return 2'd0;
    if (cd != 0) return 2'd1;
    for (int k = 0; k < N_PLAYERS; k++)
      if (rdy[k] && pos_of(p, k) == MAX_POS - 1) return 2'd3;
    return 2'd2;
  endfunction

  function automatic logic [23:0] pixel_of(input logic [1:0] scr, input int i, input logic [2:0] cd,
                                           input logic [N_PLAYERS-1:0] rdy,
                                           input logic [N_PLAYERS*POS_W-1:0] p);
    logic [23:0] c;
    c = 24'h0;
    case (scr)
      2'd0: if (i < N_PLAYERS && rdy[i]) c = pcol(i);
      2'd1: if (i < int'(cd)) c = 24'h002000;
      2'd2: for (int k = 0; k < N_PLAYERS; k++) if (rdy[k] && pos_of(p, k) == i) c |= pcol(k);
      default: begin
        for (int k = 0; k < N_PLAYERS; k++)
          if (rdy[k] && pos_of(p, k) == MAX_POS - 1) return pcol(k);
      end
    endcase
    return c;
  endfunction

  // Model: what the current cycle must show, advanced from this cycle's inputs.
  bit          model_on = 0;
  bit          m_start = 0, m_stream = 0, m_done = 0, m_pending = 1, m_post_reset = 1;
  int          m_idx = 0;
  logic [1:0]  m_screen = 2'd0;
  logic [23:0] m_frame [MAX_POS];
  int          start_cnt = 0, done_cnt = 0;
  logic [23:0] got [MAX_POS];

  always @(negedge clk) begin
    bit n_start, n_stream, n_done;
    int n_idx;
    if (model_on) begin
      chk("frame_start", frame_start, m_start);
      chk("frame_done", frame_done, m_done);
      chk("pix_valid", pix_valid, m_stream);
      chk("busy", busy, m_start | m_stream | m_done);
      chk("current_screen", current_screen, m_screen);
      if (m_stream) begin
        chk("pix_index", pix_index, m_idx);
        chk("pix_grb", pix_grb, m_frame[m_idx]);
      end
      if (m_post_reset) begin
        chk("reset_pix_index", pix_index, 0);
        chk("reset_pix_grb", pix_grb, 0);
      end

      if (frame_start) begin
        start_cnt++;
        for (int i = 0; i < MAX_POS; i++) got[i] = 24'hx;
      end
      if (frame_done) done_cnt++;
      if (pix_valid && pix_ready) got[pix_index] = pix_grb;

      if (reset_all) begin
        m_start = 0; m_stream = 0; m_done = 0; m_pending = 1;
        m_idx = 0; m_screen = 2'd0; m_post_reset = 1;
      end else begin
        n_start  = !m_start && !m_stream && m_pending;
        n_stream = m_stream;
        n_idx    = m_idx;
        n_done   = 0;
        if (m_start) begin
          n_stream = 1;
          n_idx    = 0;
          m_screen = screen_of(is_in_menu, countdown, player_ready, player_pos);
          for (int i = 0; i < MAX_POS; i++)
            m_frame[i] = pixel_of(m_screen, i, countdown, player_ready, player_pos);
        end else if (m_stream && pix_ready) begin
          if (m_idx == MAX_POS - 1) begin
            n_stream = 0;
            n_done   = 1;
          end else begin
            n_idx = m_idx + 1;
          end
        end
        m_pending    = (m_pending && !n_start) || (|player_activity) || menu_activity;
        m_start      = n_start;
        m_stream     = n_stream;
        m_done       = n_done;
        m_idx        = n_idx;
        m_post_reset = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 100) begin
      tick();
      n++;
    end
    chk("frame_done_timeout", done_cnt != d0, 1);
  endtask

  task automatic strobe_player();
    player_activity = 4'b0001;
    tick();
    player_activity = '0;
  endtask

  initial begin
    int s0, d0, n;
    tick();
    model_on = 1;
    tick();
    reset_all = 1'b0;

    // Menu screen with P0 and P2 ready, started by the reset itself.
    player_ready = 4'b0101;
    wait_done();
    chk("menu_px0", got[0], 24'h200000);
    chk("menu_px1", got[1], 24'h000000);
    chk("menu_px2", got[2], 24'h000020);
    chk("menu_px3", got[3], 24'h000000);
    chk("menu_px15", got[15], 24'h000000);
    chk("menu_screen", current_screen, 2'd0);
    tick(); tick();

    // Game screen, P0 and P1 sharing position 5.
    is_in_menu   = 1'b0;
    player_ready = 4'b0011;
    player_pos   = {4'd0, 4'd9, 4'd5, 4'd5};
    strobe_player();
    wait_done();
    chk("game_px5", got[5], 24'h202000);
    chk("game_px4", got[4], 24'h000000);
    chk("game_px9", got[9], 24'h000000);
    chk("game_screen", current_screen, 2'd2);
    tick(); tick();

    // Backpressure: pix_ready alternating during the whole frame.
    strobe_player();
    for (int i = 0; i < 40 && !frame_done; i++) begin
      pix_ready = ~pix_ready;
      tick();
    end
    pix_ready = 1'b1;
    chk("stall_px5", got[5], 24'h202000);
    tick(); tick(); tick();

    // Three strobes inside one frame coalesce into a single follow-up frame.
    s0 = start_cnt;
    strobe_player();
    tick(); tick(); tick();
    menu_activity = 1'b1; tick(); menu_activity = 1'b0;
    tick();
    player_activity = 4'b0100; tick(); player_activity = '0;
    tick();
    menu_activity = 1'b1; tick(); menu_activity = 1'b0;
    wait_done();
    wait_done();
    repeat (25) tick();
    chk("coalesce_frames", start_cnt - s0, 2);

    // Countdown of 3.
    countdown = 3'd3;
    strobe_player();
    wait_done();
    chk("cd_px0", got[0], 24'h002000);
    chk("cd_px2", got[2], 24'h002000);
    chk("cd_px3", got[3], 24'h000000);
    chk("cd_screen", current_screen, 2'd1);
    tick(); tick();

    // Win: P3 ready at the final position, no countdown.
    countdown    = 3'd0;
    player_ready = 4'b1000;
    player_pos   = {4'd15, 4'd3, 4'd2, 4'd1};
    strobe_player();
    wait_done();
    chk("win_px0", got[0], 24'h202000);
    chk("win_px15", got[15], 24'h202000);
    chk("win_screen", current_screen, 2'd3);
    tick(); tick();

    // Reset while pixel 7 is on offer aborts the frame without frame_done.
    strobe_player();
    n = 0;
    while (!(pix_valid && pix_index == 7) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_px7", pix_valid && pix_index == 7, 1);
    d0 = done_cnt;
    reset_all = 1'b1;
    tick();
    reset_all = 1'b0;
    tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_valid_low", pix_valid, 0);
    wait_done();
    chk("restart_done", done_cnt - d0, 1);
    chk("restart_px0", got[0], 24'h202000);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      pix_ready       = ($urandom_range(0, 3) != 0);
      player_activity = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : '0;
      menu_activity   = ($urandom_range(0, 19) == 0);
      is_in_menu      = ($urandom_range(0, 3) == 0);
      countdown       = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      player_ready    = 4'($urandom_range(0, 15));
      for (int k = 0; k < N_PLAYERS; k++)
        player_pos[k*POS_W +: POS_W] = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      reset_all       = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset_all       = 1'b0;
    player_activity = '0;
    menu_activity   = 1'b0;
    pix_ready       = 1'b1;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_renderer.md
FRAME_RENDERER -- requirements
Module: frame_renderer

Interface
REQ-001 SHALL have parameter MAX_POS, default 16, meaning number of LEDs in chain and track length.
REQ-002 SHALL have parameter N_PLAYERS, default 4, meaning number of player channels; legal range 1..4.
REQ-003 SHALL have local constant POS_W = $clog2(MAX_POS).
REQ-004 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset_all  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port player_ready  in  N_PLAYERS  per-player ready_to_play.
REQ-007 SHALL have port player_pos  in  N_PLAYERS*POS_W  packed positions; player k at bits [k*POS_W +: POS_W].
REQ-008 SHALL have port player_activity  in  N_PLAYERS  per-player activity strobe.
REQ-009 SHALL have port menu_activity  in  1  menu activity strobe.
REQ-010 SHALL have port is_in_menu  in  1  menu mode flag.
REQ-011 SHALL have port countdown  in  3  countdown value, 0 = none.
REQ-012 SHALL have port pix_valid  out  1  pixel offered to LED driver.
REQ-013 SHALL have port pix_ready  in  1  LED driver accepts pixel.
REQ-014 SHALL have port pix_index  out  POS_W  LED index of offered pixel.
REQ-015 SHALL have port pix_grb  out  24  pixel colour, G[23:16] R[15:8] B[7:0].
REQ-016 SHALL have port frame_start  out  1  one-cycle pulse, frame begins.
REQ-017 SHALL have port frame_done  out  1  one-cycle pulse, last pixel accepted.
REQ-018 SHALL have port busy  out  1  high from SNAPSHOT through DONE.
REQ-019 SHALL have port current_screen  out  2  screen of frame in flight / last rendered.

Function
REQ-020 SHALL set pending on any cycle where |player_activity, menu_activity, or reset_all is high; pending cleared on entry to SNAPSHOT.
REQ-021 SHALL implement FSM IDLE -> SNAPSHOT (1 cycle) -> STREAM -> DONE (1 cycle) -> IDLE.
REQ-022 SHALL leave IDLE for SNAPSHOT when pending=1; frame_start pulses in SNAPSHOT cycle.
REQ-023 SHALL in SNAPSHOT register player_ready, player_pos, is_in_menu, countdown; whole frame rendered from snapshot (no tearing).
REQ-024 SHALL in SNAPSHOT compute current_screen, priority MENU(0) > COUNTDOWN(1, countdown!=0) > WIN(3, any ready player at pos MAX_POS-1) > GAME(2).
REQ-025 SHALL in STREAM offer pixels index 0..MAX_POS-1 in order; pix_valid first high cycle after SNAPSHOT.
REQ-026 SHALL hold pix_index and pix_grb stable while pix_valid=1 and pix_ready=0; advance only on valid&&ready.
REQ-027 SHALL accept back-to-back pixels at 1 per cycle when pix_ready held high; frame_done asserted cycle after last accept (latency SNAPSHOT + MAX_POS + 1 cycles minimum).
REQ-028 SHALL coalesce all activity during a frame into one pending request; DONE -> SNAPSHOT directly if pending, else IDLE.
REQ-029 SHALL use player colours at intensity 8'h20: P0 green, P1 red, P2 blue, P3 yellow (G=R=8'h20).
REQ-030 SHALL render GAME: pixel i = bitwise OR of colours of ready players with pos==i; else black.
REQ-031 SHALL render MENU: pixel i<N_PLAYERS = player i colour if ready else black; others black.
REQ-032 SHALL render COUNTDOWN: pixels i<countdown red (R=8'h20); others black.
REQ-033 SHALL render WIN: all pixels = colour of lowest-index ready player at MAX_POS-1.
REQ-034 SHALL treat pix_ready while pix_valid=0 as don't-care.

Reset
REQ-035 SHALL on reset_all: state IDLE, pix_valid 0, pix_index 0, pix_grb 0, frame_start 0, frame_done 0, busy 0, current_screen 0; pending set.
REQ-036 SHALL abort any frame in flight on reset_all without frame_done; first frame starts SNAPSHOT on first cycle after reset_all deasserts.

Structure
REQ-037 SHALL place screen codes, colour constants, intensity in shared package display_pkg.
REQ-038 SHALL put per-pixel colour lookup in combinational sub-module pixel_colorizer (inputs: screen, index, snapshot; output: grb).

Verification
REQ-039 SHALL cover: reset then pix_ready=1, N=4, all in menu, P0,P2 ready -> frame_start, 16 pixels, idx0=0x200000, idx2=0x000020, others 0, frame_done.
REQ-040 SHALL cover: GAME, P0 and P1 at pos 5 -> pixel 5 = 0x202000, others 0.
REQ-041 SHALL cover: pix_ready toggling 1/0 -> pix_index/pix_grb stable during stalls, no skipped or repeated index.
REQ-042 SHALL cover: three activity strobes mid-frame -> exactly one extra frame, SNAPSHOT cycle after DONE.
REQ-043 SHALL cover: countdown=3 -> pixels 0..2 = 0x002000, screen=1; P3 at pos 15 ready, no countdown -> all pixels 0x202000, screen=3.
REQ-044 SHALL cover: reset_all at pixel 7 -> pix_valid low next cycle, no frame_done, new frame from index 0.
